// File: rtl/trig_capture_ctrl_pkg.sv
// trig_capture_ctrl_pkg: capture controller state encoding and register offsets
package trig_capture_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_CAPTURE, S_HOLDOFF} state_t;
  localparam logic [7:0] REG_CTRL = 8'd0;
  localparam logic [7:0] REG_PRETRIG = 8'd1;
  localparam logic [7:0] REG_POST = 8'd2;
  localparam logic [7:0] REG_HOLDOFF = 8'd3;
endpackage

// File: rtl/setting_reg.sv
// setting_reg: one settings-bus register decoded at a fixed address
module setting_reg #(
  parameter int MY_ADDR = 0,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_strobe,
  input  logic [7:0]       i_addr,
  input  logic [31:0]      i_data,
  output logic [WIDTH-1:0] o_data
);
  always_ff @(posedge clock)
    if (reset) o_data <= '0;
    else if (i_strobe && i_addr == 8'(MY_ADDR)) o_data <= WIDTH'(i_data);
endmodule

// File: rtl/trig_capture_ctrl_strobe_counter.sv
// strobe_counter: loadable 16-bit counter advancing on strobe, flags a terminal value
module strobe_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_stb,
  input  logic [15:0] i_term,
  output logic        o_tc
);
  logic [15:0] r_count;
  always_ff @(posedge clock)
    if (reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_stb) r_count <= r_count + 16'd1;
  assign o_tc = r_count == i_term;
endmodule

// File: rtl/trig_capture_ctrl.sv
// trig_capture_ctrl: pretrigger fill, trigger arm, burst capture and holdoff gating
module trig_capture_ctrl
  import trig_capture_ctrl_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        in_strobe,
  input  logic        trig_in,
  output logic [8:0]  rd_delay,
  output logic        pass,
  output logic        sob,
  output logic        eob,
  output logic        armed,
  output logic        busy,
  output logic [15:0] trig_count
);
  logic [2:0]  w_ctrl;
  logic [8:0]  w_pretrig;
  logic [15:0] w_post, w_hold;
  logic        r_ctrl_wr;
  state_t      r_state, w_next, w_after, w_after_hold;
  logic [8:0]  r_pretrig;
  logic [15:0] r_post, r_hold, r_trig_count;
  logic        r_cont, r_force, r_pass, r_sob, r_eob;
  logic        w_arm, w_force, w_abort, w_take, w_cap, w_cap_last, w_burst_end, w_tc, w_cnt_load;
  logic [15:0] w_cnt_val, w_cnt_term;

  setting_reg #(.MY_ADDR(BASE + int'(REG_CTRL)), .WIDTH(3)) u_ctrl (
    .clock(clock), .reset(reset), .i_strobe(set_stb), .i_addr(set_addr), .i_data(set_data), .o_data(w_ctrl));
  setting_reg #(.MY_ADDR(BASE + int'(REG_PRETRIG)), .WIDTH(9)) u_pretrig (
    .clock(clock), .reset(reset), .i_strobe(set_stb), .i_addr(set_addr), .i_data(set_data), .o_data(w_pretrig));
  setting_reg #(.MY_ADDR(BASE + int'(REG_POST)), .WIDTH(16)) u_post (
    .clock(clock), .reset(reset), .i_strobe(set_stb), .i_addr(set_addr), .i_data(set_data), .o_data(w_post));
  setting_reg #(.MY_ADDR(BASE + int'(REG_HOLDOFF)), .WIDTH(16)) u_hold (
    .clock(clock), .reset(reset), .i_strobe(set_stb), .i_addr(set_addr), .i_data(set_data), .o_data(w_hold));

  // arm and force act only in the cycle right after a ctrl write, making them self-clearing
  assign w_arm = r_ctrl_wr & w_ctrl[0];
  assign w_force = r_ctrl_wr & w_ctrl[2];
  assign w_abort = clear | ~enable;
  assign w_take = ~w_abort & (r_state == S_ARMED) & in_strobe & (trig_in | r_force | w_force);
  assign w_cap = ~w_abort & (r_state == S_CAPTURE) & in_strobe;
  assign w_cap_last = w_cap & w_tc;
  assign w_burst_end = (w_take & (r_post <= 16'd1)) | w_cap_last;
  assign w_after_hold = r_cont ? S_ARMED : S_IDLE;
  assign w_after = (r_hold != 16'd0) ? S_HOLDOFF : w_after_hold;

  // the counter holds samples passed so far in CAPTURE, so it restarts at 1 on the trigger
  assign w_cnt_load = w_abort | (w_next != r_state);
  assign w_cnt_val = (w_next == S_CAPTURE) ? 16'd1 : 16'd0;
  assign w_cnt_term = (r_state == S_FILL) ? {7'd0, r_pretrig} :
                      (r_state == S_CAPTURE) ? r_post - 16'd1 : r_hold - 16'd1;

  strobe_counter u_cnt (
    .clock(clock), .reset(reset), .i_load(w_cnt_load), .i_load_val(w_cnt_val),
    .i_stb(in_strobe), .i_term(w_cnt_term), .o_tc(w_tc));

  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:    if (w_arm | w_ctrl[1]) w_next = S_FILL;
        S_FILL:    if (w_tc) w_next = S_ARMED;
        S_ARMED:   if (w_take) w_next = (r_post <= 16'd1) ? w_after : S_CAPTURE;
        S_CAPTURE: if (w_cap_last) w_next = w_after;
        S_HOLDOFF: if (in_strobe & w_tc) w_next = w_after_hold;
        default:   w_next = S_IDLE;
      endcase
  end

  always_ff @(posedge clock)
    if (reset) begin
      r_ctrl_wr <= 1'b0;
      r_state <= S_IDLE;
      r_pretrig <= '0;
      r_post <= '0;
      r_hold <= '0;
      r_cont <= 1'b0;
      r_force <= 1'b0;
      r_pass <= 1'b0;
      r_sob <= 1'b0;
      r_eob <= 1'b0;
      r_trig_count <= '0;
    end else begin
      r_ctrl_wr <= set_stb & (set_addr == 8'(BASE) + REG_CTRL);
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_FILL) begin
        r_pretrig <= w_pretrig;
        r_post <= w_post;
        r_hold <= w_hold;
        r_cont <= w_ctrl[1];
      end
      r_force <= (r_state == S_ARMED) & ~w_abort & ~w_take & (r_force | w_force);
      r_pass <= w_take | w_cap;
      r_sob <= w_take;
      r_eob <= w_burst_end;
      r_trig_count <= w_abort ? 16'd0 : r_trig_count + {15'd0, w_take};
    end

  assign rd_delay = w_pretrig;
  assign pass = r_pass;
  assign sob = r_sob;
  assign eob = r_eob;
  assign armed = r_state == S_ARMED;
  assign busy = r_state != S_IDLE;
  assign trig_count = r_trig_count;
endmodule

// File: tb/tb_trig_capture_ctrl.sv
// tb_trig_capture_ctrl: directed vector and sequence checks of the capture controller
module tb_trig_capture_ctrl;
  localparam int B = 16;
  logic        clock = 1'b0;
  logic        reset, clear, enable, set_stb, in_strobe, trig_in;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [8:0]  rd_delay;
  logic        pass, sob, eob, armed, busy;
  logic [15:0] trig_count;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       stb;
    logic       trig;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];

  trig_capture_ctrl #(.BASE(B)) dut (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_strobe(in_strobe), .trig_in(trig_in), .rd_delay(rd_delay),
    .pass(pass), .sob(sob), .eob(eob), .armed(armed), .busy(busy), .trig_count(trig_count));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {pass, sob, eob, armed, busy}
  function automatic logic [4:0] outs();
    return {pass, sob, eob, armed, busy};
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    in_strobe = 1'b0;
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic step(input logic s, input logic t);
    in_strobe = s;
    trig_in = t;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    enable = 1'b1;
    in_strobe = 1'b0;
    trig_in = 1'b0;
    set_stb = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic add(input logic s, input logic t, input logic [4:0] e);
    vec_t v;
    v.stb = s;
    v.trig = t;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    add(0, 0, 5'b00001);
    for (int i = 0; i < 4; i++) add(1, 0, 5'b00001);
    add(1, 0, 5'b00011);
    for (int i = 0; i < 4; i++) add(1, 0, 5'b00011);
    add(1, 1, 5'b11001);
    for (int i = 0; i < 3; i++) add(1, 0, 5'b10001);
    add(0, 0, 5'b00001);
    for (int i = 0; i < 3; i++) add(1, 0, 5'b10001);
    add(1, 1, 5'b10100);
    add(1, 1, 5'b00000);

    // reset state, with a settings write held off by reset
    reset = 1'b1; clear = 1'b0; enable = 1'b1; in_strobe = 1'b0; trig_in = 1'b0;
    set_stb = 1'b1; set_addr = 8'(B + 1); set_data = 32'd9;
    tick(); tick();
    set_stb = 1'b0;
    chk("reset_outs", outs(), 5'b00000);
    chk("reset_trig_count", trig_count, 0);
    chk("reset_rd_delay", rd_delay, 0);
    reset = 1'b0;

    // one-shot capture: pretrig 4, post 8
    wr(8'(B + 1), 4); wr(8'(B + 2), 8); wr(8'(B + 3), 0);
    chk("rd_delay_4", rd_delay, 4);
    wr(8'(B), 1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].stb, tbl[i].trig);
      chk($sformatf("oneshot_vec%0d", i), outs(), tbl[i].exp);
    end
    chk("oneshot_trig_count", trig_count, 1);

    // continuous, post 2, holdoff 3, trigger held high
    do_reset();
    wr(8'(B + 1), 0); wr(8'(B + 2), 2); wr(8'(B + 3), 3);
    wr(8'(B), 2);
    step(1, 1);
    chk("cont_fill", outs(), 5'b00001);
    step(1, 1);
    chk("cont_armed", outs(), 5'b00011);
    for (int k = 0; k < 15; k++) begin
      step(1, 1);
      chk($sformatf("cont_k%0d", k), outs(), {k % 5 < 2, k % 5 == 0, k % 5 == 1, k % 5 == 4, 1'b1});
    end
    chk("cont_trig_count", trig_count, 3);

    // force in IDLE is discarded; force while ARMED captures on the next strobe
    do_reset();
    wr(8'(B + 1), 0); wr(8'(B + 2), 1);
    wr(8'(B), 4);
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk($sformatf("force_idle%0d", i), outs(), 5'b00000);
    end
    wr(8'(B), 1);
    step(0, 0);
    chk("pretrig0_fill", outs(), 5'b00001);
    step(0, 0);
    chk("pretrig0_armed", outs(), 5'b00011);
    for (int i = 0; i < 3; i++) step(1, 0);
    chk("force_not_stale", outs(), 5'b00011);
    wr(8'(B), 4);
    step(0, 0);
    chk("force_pending", outs(), 5'b00011);
    step(1, 0);
    chk("force_capture", outs(), 5'b11100);
    chk("force_trig_count", trig_count, 1);
    step(1, 0);
    chk("force_idle_after", outs(), 5'b00000);

    // post_len 0 gives a single sample
    do_reset();
    wr(8'(B + 1), 0); wr(8'(B + 2), 0);
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    chk("post0_single", outs(), 5'b11100);
    step(1, 1);
    chk("post0_done", outs(), 5'b00000);

    // pretrig 511
    do_reset();
    wr(8'(B + 1), 511); wr(8'(B + 2), 1);
    chk("rd_delay_511", rd_delay, 511);
    wr(8'(B), 1);
    step(0, 0);
    for (int i = 0; i < 511; i++) step(1, 0);
    chk("pretrig511_still_fill", outs(), 5'b00001);
    step(0, 0);
    chk("pretrig511_armed", outs(), 5'b00011);

    // abort by enable mid-capture
    do_reset();
    wr(8'(B + 1), 0); wr(8'(B + 2), 8);
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    step(1, 0);
    chk("abort_en_mid", outs(), 5'b10001);
    enable = 1'b0;
    step(1, 0);
    chk("abort_en", outs(), 5'b00000);
    enable = 1'b1;
    step(0, 0);
    chk("abort_en_idle", outs(), 5'b00000);

    // clear on the would-be last sample: no eob
    wr(8'(B + 2), 2);
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    chk("clear_first", outs(), 5'b11001);
    clear = 1'b1;
    step(1, 0);
    chk("clear_abort", outs(), 5'b00000);
    clear = 1'b0;
    step(1, 1);
    chk("clear_idle", outs(), 5'b00000);

    // reset mid-burst
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    wr(8'(B + 1), 5);
    chk("pre_reset_rd_delay", rd_delay, 5);
    reset = 1'b1;
    step(1, 0);
    reset = 1'b0;
    chk("reset_mid_outs", outs(), 5'b00000);
    chk("reset_mid_count", trig_count, 0);
    chk("reset_mid_rd_delay", rd_delay, 0);

    // post_len written mid-burst applies to the next burst
    do_reset();
    wr(8'(B + 1), 0); wr(8'(B + 2), 3);
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    n = int'(pass);
    wr(8'(B + 2), 5);
    n += int'(pass);
    for (int i = 0; i < 6; i++) begin
      step(1, 0);
      n += int'(pass);
    end
    chk("latched_burst1", n, 3);
    chk("latched_idle", outs(), 5'b00000);
    wr(8'(B), 1);
    step(0, 0); step(0, 0);
    step(1, 1);
    n = int'(pass);
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      n += int'(pass);
    end
    chk("latched_burst2", n, 5);
    chk("latched_trig_count", trig_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trig_capture_ctrl.md
TRIG_CAPTURE_CTRL -- requirements
Module: trig_capture_ctrl

Interface
REQ-001 Parameter BASE, default 0, settings-bus base address; the block decodes BASE+0..BASE+3.
REQ-002 clock  in  1  DSP clock; all logic is rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 clear  in  1  active-high packet-control init; aborts to IDLE.
REQ-005 enable  in  1  streaming enable; low forces IDLE.
REQ-006 set_stb/set_addr/set_data  in  1/8/32  user settings bus.
REQ-007 in_strobe  in  1  valid-sample strobe from the DDC.
REQ-008 trig_in  in  1  power-over-threshold flag; sampled only when in_strobe=1.
REQ-009 rd_delay  out  9  pretrigger depth for the delay-line read offset.
REQ-010 pass  out  1  gate for the baseband strobe.
REQ-011 sob, eob  out  1 each  start-of-burst and end-of-burst flags, coincident with pass.
REQ-012 armed  out  1  high in the ARMED state.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 trig_count  out  16  number of accepted triggers; wraps.

Function
REQ-015 Settings registers:
- BASE+0 ctrl: bit0 arm (self-clearing pulse); bit1 continuous; bit2 force (self-clearing pulse).
- BASE+1 pretrig[8:0].
- BASE+2 post_len[15:0].
- BASE+3 holdoff[15:0].
REQ-016 rd_delay SHALL equal pretrig.
REQ-017 Pretrig, post_len, holdoff and continuous SHALL be latched into working registers on entry to FILL; writes made mid-burst do not affect the current burst.
REQ-018 States: IDLE, FILL, ARMED, CAPTURE, HOLDOFF. All counters advance only on in_strobe.
REQ-019 IDLE -> FILL on an arm pulse, or when continuous=1 and enable=1. The fill counter loads 0.
REQ-020 FILL: the counter increments per strobe. FILL -> ARMED when count == pretrig. If pretrig=0, FILL -> ARMED on the next cycle.
REQ-021 ARMED -> CAPTURE on a strobe with (trig_in | force_pending).
- force_pending is set by the force pulse and cleared when consumed; a force pulse in any other state is discarded.
- The triggering sample is the first passed sample.
- trig_count increments.
REQ-022 CAPTURE passes exactly max(post_len,1) strobed samples.
REQ-023 pass, sob and eob are registered and assert exactly one cycle after the qualifying in_strobe, which matches the delay-line read latency.
- sob marks the first passed sample; eob marks the last.
- When post_len is 0 or 1, sob and eob assert together.
REQ-024 After the last passed sample:
- if holdoff > 0 -> HOLDOFF;
- otherwise -> ARMED if continuous, else IDLE.
REQ-025 HOLDOFF counts holdoff strobes with pass=0, then -> ARMED if continuous, else IDLE.
REQ-026 An arm pulse in any state other than IDLE is ignored.
REQ-027 enable=0 or clear=1 in any state:
- next state is IDLE;
- counters are zeroed;
- force_pending is cleared;
- a pending eob is suppressed, so an aborted burst carries no eob.
REQ-028 When in_strobe and a state-exit condition coincide with clear, clear wins.

Reset
REQ-029 Reset SHALL force:
- state IDLE;
- all settings and working registers to 0;
- pass, sob, eob, armed, busy to 0;
- trig_count to 0;
- force_pending to 0.
REQ-030 Reset SHALL take precedence over clear, enable and the settings bus.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the register offset constants (CTRL=0, PRETRIG=1, POST=2, HOLDOFF=3).
REQ-032 A single sub-module, strobe_counter, SHALL provide a loadable 16-bit counter with strobe enable and terminal-count flag; FILL, CAPTURE and HOLDOFF all reuse it.
REQ-033 The settings decode SHALL use the team's existing setting_reg block.

Verification
REQ-034 One-shot capture:
- Stimulus: pretrig=4, post_len=8, holdoff=0, arm, then 10 strobes; trig_in high on strobe 10.
- Response: exactly 8 pass cycles; sob on the 1st, eob on the 8th; return to IDLE; trig_count=1.
REQ-035 Continuous mode with holdoff:
- Stimulus: continuous=1, post_len=2, holdoff=3, trig_in held high.
- Response: bursts of 2 samples separated by 3 non-passed strobes; trig_count increments each burst.
REQ-036 Forced trigger:
- Stimulus: arm with trig_in=0, force pulse while ARMED.
- Response: capture starts on the next strobe.
- Also: a force pulse issued in IDLE produces no capture.
REQ-037 Boundary values:
- post_len=0 -> a single sample, with sob and eob together.
- pretrig=0 -> ARMED one cycle after arm.
- pretrig=511 -> ARMED after 511 strobes.
REQ-038 Abort:
- Stimulus: deassert enable, then separately assert clear, each mid-CAPTURE.
- Response: pass drops the next cycle; no eob; state IDLE.
- Also: reset asserted mid-burst clears all outputs.
REQ-039 Latched settings:
- Stimulus: write post_len=5 during a capture running with post_len=3.
- Response: the current burst passes 3 samples; the next armed burst passes 5.
